sound_event_scheduler: RTL

Shares the game's single sound_to_play channel among several event sources: ship movement, score increment, hit, title jingle and similar. Sources fire one-cycle or level requests. The block latches them as pending, grants one at a time by fixed priority, holds the sound code for a fixed play time, then inserts a silent gap before the next grant. It sits between the game logic and the audio generator, replacing direct writes to sound_to_play.

---
 rtl/sound_event_scheduler.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sound_event_scheduler.sv
// Arbitrates event sources onto one sound channel: fixed priority, timed play, silent gap.
// Latency: req in cycle c -> sound/grant in c+2 from IDLE; no backpressure, repeat requests coalesce.
module sound_event_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int PLAY_TICKS = 6250000,
    parameter int GAP_TICKS  = 250000,
    parameter int CNT_W      = 24,
    parameter bit PREEMPT    = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               mute,
    output logic [2:0]         sound_to_play,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] PLAY_LOAD = CNT_W'(PLAY_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_TICKS - 1);

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] pending, pending_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [NUM_REQ-1:0] sel_onehot;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [2:0]         sound_nxt;
    logic [2:0]         sel_code;
    logic               preempt_hit;

    // Lowest set pending index wins; scanning downward lets it overwrite higher ones.
    always_comb begin
        sel_onehot = '0;
        sel_code   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
                sel_code      = 3'(i + 1);
            end
        end
    end

    // sound_to_play holds k+1 during PLAY, so index i outranks k when i+1 < sound_to_play.
    always_comb begin
        preempt_hit = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PREEMPT && pending[i] && (3'(i + 1) < sound_to_play)) begin
                preempt_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        sound_nxt   = sound_to_play;
        grant_nxt   = '0;
        pending_nxt = pending;

        case (state)
            IDLE: begin
                if (|pending) begin
                    state_nxt   = PLAY;
                    sound_nxt   = sel_code;
                    grant_nxt   = sel_onehot;
                    pending_nxt = pending & ~sel_onehot;
                    cnt_nxt     = PLAY_LOAD;
                end
            end
            PLAY: begin
                if (preempt_hit || (cnt == '0)) begin
                    state_nxt = GAP;
                    sound_nxt = 3'd0;
                    cnt_nxt   = GAP_LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                sound_nxt = 3'd0;
                cnt_nxt   = '0;
            end
        endcase

        // A new request in the same cycle as its grant survives the clear and replays later.
        pending_nxt = pending_nxt | req;

        if (mute) begin
            state_nxt   = IDLE;
            pending_nxt = '0;
            cnt_nxt     = '0;
            sound_nxt   = 3'd0;
            grant_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            pending       <= '0;
            cnt           <= '0;
            sound_to_play <= 3'd0;
            grant         <= '0;
        end else begin
            state         <= state_nxt;
            pending       <= pending_nxt;
            cnt           <= cnt_nxt;
            sound_to_play <= sound_nxt;
            grant         <= grant_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule
